// File: rtl/commit_lockstep_checker_if.sv
// Control, commit-record and diagnostic bundle between a lockstep checker and its environment.
// The master side drives both cores' commit records and the control inputs.
interface commit_lockstep_checker_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned ILEN  = 32,
  parameter int unsigned CNT_W = 32
);
  logic             en;
  logic             clear;
  logic [2:0]       cmp_mask;

  logic             dut_valid;
  logic [XLEN-1:0]  dut_pc;
  logic [ILEN-1:0]  dut_instr;
  logic [XLEN-1:0]  dut_wdata;

  logic             ref_valid;
  logic [XLEN-1:0]  ref_pc;
  logic [ILEN-1:0]  ref_instr;
  logic [XLEN-1:0]  ref_wdata;

  logic [1:0]       state;
  logic             halt;
  logic [1:0]       fail_code;
  logic [XLEN-1:0]  fail_dut_pc;
  logic [XLEN-1:0]  fail_ref_pc;
  logic [2:0]       fail_field;
  logic [CNT_W-1:0] match_cnt;

  modport master (
    output en, clear, cmp_mask,
    output dut_valid, dut_pc, dut_instr, dut_wdata,
    output ref_valid, ref_pc, ref_instr, ref_wdata,
    input  state, halt, fail_code, fail_dut_pc, fail_ref_pc, fail_field, match_cnt
  );

  modport slave (
    input  en, clear, cmp_mask,
    input  dut_valid, dut_pc, dut_instr, dut_wdata,
    input  ref_valid, ref_pc, ref_instr, ref_wdata,
    output state, halt, fail_code, fail_dut_pc, fail_ref_pc, fail_field, match_cnt
  );
endinterface

// File: rtl/commit_lockstep_checker.sv
// Lockstep commit checker: buffers retired records from two cores in per-side skew FIFOs,
// compares matched heads under a field mask and latches the first failure with a halt request.
module commit_lockstep_checker #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned ILEN    = 32,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  commit_lockstep_checker_if.slave bus
);
  localparam int unsigned PW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = PW + 1;
  localparam int unsigned TW    = $clog2(TIMEOUT) + 1;
  localparam int unsigned RW    = 2 * XLEN + ILEN;

  localparam logic [1:0] CodeNone     = 2'd0;
  localparam logic [1:0] CodeMismatch = 2'd1;
  localparam logic [1:0] CodeOverflow = 2'd2;
  localparam logic [1:0] CodeTimeout  = 2'd3;

  typedef enum logic [1:0] {StIdle = 2'd0, StRun = 2'd1, StFail = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [PTR_W-1:0] dut_wp_q, dut_wp_d, dut_rp_q, dut_rp_d;
  logic [PTR_W-1:0] ref_wp_q, ref_wp_d, ref_rp_q, ref_rp_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             cmp_vld_q, cmp_vld_d;
  logic [2:0]       cmp_field_q, cmp_field_d;
  logic [XLEN-1:0]  cmp_dut_pc_q, cmp_dut_pc_d, cmp_ref_pc_q, cmp_ref_pc_d;
  logic             halt_q, halt_d;
  logic [1:0]       fail_code_q, fail_code_d;
  logic [2:0]       fail_field_q, fail_field_d;
  logic [XLEN-1:0]  fail_dut_pc_q, fail_dut_pc_d, fail_ref_pc_q, fail_ref_pc_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic [RW-1:0]    dut_mem [DEPTH];
  logic [RW-1:0]    ref_mem [DEPTH];
  logic [RW-1:0]    dut_head, ref_head;
  logic [XLEN-1:0]  dut_head_pc, ref_head_pc;
  logic             dut_empty, ref_empty, dut_full, ref_full;
  logic             run, pop, dut_push, ref_push, dut_ovf, ref_ovf, skew;
  logic [2:0]       diff;

  // Record layout: {pc, instr, wdata}.
  assign dut_head    = dut_mem[dut_rp_q[PW-1:0]];
  assign ref_head    = ref_mem[ref_rp_q[PW-1:0]];
  assign dut_head_pc = dut_head[RW-1 -: XLEN];
  assign ref_head_pc = ref_head[RW-1 -: XLEN];

  assign dut_empty = (dut_wp_q == dut_rp_q);
  assign ref_empty = (ref_wp_q == ref_rp_q);
  assign dut_full  = ((dut_wp_q ^ dut_rp_q) == {1'b1, {PW{1'b0}}});
  assign ref_full  = ((ref_wp_q ^ ref_rp_q) == {1'b1, {PW{1'b0}}});

  assign run      = (state_q == StRun) && !bus.clear;
  assign pop      = run && !dut_empty && !ref_empty;
  // A full FIFO that pops this cycle still has room for the incoming record.
  assign dut_push = run && bus.dut_valid && (!dut_full || pop);
  assign ref_push = run && bus.ref_valid && (!ref_full || pop);
  assign dut_ovf  = run && bus.dut_valid && dut_full && !pop;
  assign ref_ovf  = run && bus.ref_valid && ref_full && !pop;
  assign skew     = run && (dut_empty != ref_empty);

  assign diff = {dut_head[XLEN-1:0] != ref_head[XLEN-1:0],
                 dut_head[XLEN +: ILEN] != ref_head[XLEN +: ILEN],
                 dut_head_pc != ref_head_pc} & bus.cmp_mask;

  always_comb begin
    state_d       = state_q;
    halt_d        = halt_q;
    fail_code_d   = fail_code_q;
    fail_field_d  = fail_field_q;
    fail_dut_pc_d = fail_dut_pc_q;
    fail_ref_pc_d = fail_ref_pc_q;
    match_cnt_d   = match_cnt_q;
    cmp_vld_d     = pop;
    cmp_field_d   = diff;
    cmp_dut_pc_d  = dut_head_pc;
    cmp_ref_pc_d  = ref_head_pc;
    timer_d       = skew ? timer_q + TW'(1) : '0;
    dut_wp_d      = dut_wp_q + PTR_W'(dut_push);
    ref_wp_d      = ref_wp_q + PTR_W'(ref_push);
    dut_rp_d      = dut_rp_q + PTR_W'(pop);
    ref_rp_d      = ref_rp_q + PTR_W'(pop);

    if (bus.clear) begin
      state_d       = StIdle;
      halt_d        = 1'b0;
      fail_code_d   = CodeNone;
      fail_field_d  = '0;
      fail_dut_pc_d = '0;
      fail_ref_pc_d = '0;
      match_cnt_d   = '0;
      cmp_vld_d     = 1'b0;
      timer_d       = '0;
      dut_wp_d      = '0;
      dut_rp_d      = '0;
      ref_wp_d      = '0;
      ref_rp_d      = '0;
    end else begin
      unique case (state_q)
        StIdle: if (bus.en) state_d = StRun;
        StRun: begin
          if (cmp_vld_q && (cmp_field_q != 3'b000)) begin
            state_d       = StFail;
            halt_d        = 1'b1;
            fail_code_d   = CodeMismatch;
            fail_field_d  = cmp_field_q;
            fail_dut_pc_d = cmp_dut_pc_q;
            fail_ref_pc_d = cmp_ref_pc_q;
          end else if (dut_ovf || ref_ovf ||
                       (skew && (timer_q == TW'(TIMEOUT - 1)))) begin
            state_d       = StFail;
            halt_d        = 1'b1;
            fail_code_d   = (dut_ovf || ref_ovf) ? CodeOverflow : CodeTimeout;
            fail_field_d  = '0;
            fail_dut_pc_d = dut_empty ? '0 : dut_head_pc;
            fail_ref_pc_d = ref_empty ? '0 : ref_head_pc;
          end
          if (cmp_vld_q && (cmp_field_q == 3'b000) && (match_cnt_q != {CNT_W{1'b1}})) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (dut_push) dut_mem[dut_wp_q[PW-1:0]] <= {bus.dut_pc, bus.dut_instr, bus.dut_wdata};
    if (ref_push) ref_mem[ref_wp_q[PW-1:0]] <= {bus.ref_pc, bus.ref_instr, bus.ref_wdata};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      halt_q        <= 1'b0;
      fail_code_q   <= CodeNone;
      fail_field_q  <= '0;
      fail_dut_pc_q <= '0;
      fail_ref_pc_q <= '0;
      match_cnt_q   <= '0;
      cmp_vld_q     <= 1'b0;
      cmp_field_q   <= '0;
      cmp_dut_pc_q  <= '0;
      cmp_ref_pc_q  <= '0;
      timer_q       <= '0;
      dut_wp_q      <= '0;
      dut_rp_q      <= '0;
      ref_wp_q      <= '0;
      ref_rp_q      <= '0;
    end else begin
      state_q       <= state_d;
      halt_q        <= halt_d;
      fail_code_q   <= fail_code_d;
      fail_field_q  <= fail_field_d;
      fail_dut_pc_q <= fail_dut_pc_d;
      fail_ref_pc_q <= fail_ref_pc_d;
      match_cnt_q   <= match_cnt_d;
      cmp_vld_q     <= cmp_vld_d;
      cmp_field_q   <= cmp_field_d;
      cmp_dut_pc_q  <= cmp_dut_pc_d;
      cmp_ref_pc_q  <= cmp_ref_pc_d;
      timer_q       <= timer_d;
      dut_wp_q      <= dut_wp_d;
      dut_rp_q      <= dut_rp_d;
      ref_wp_q      <= ref_wp_d;
      ref_rp_q      <= ref_rp_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.halt        = halt_q;
  assign bus.fail_code   = fail_code_q;
  assign bus.fail_field  = fail_field_q;
  assign bus.fail_dut_pc = fail_dut_pc_q;
  assign bus.fail_ref_pc = fail_ref_pc_q;
  assign bus.match_cnt   = match_cnt_q;

endmodule

// File: tb/tb_commit_lockstep_checker.sv
// Bench for commit_lockstep_checker: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a queue-based model of the two commit streams.
module tb_commit_lockstep_checker;
  localparam int unsigned XLEN    = 32;
  localparam int unsigned ILEN    = 32;
  localparam int unsigned DEPTH   = 8;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wdata;
  } rec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  commit_lockstep_checker_if #(.XLEN(XLEN), .ILEN(ILEN), .CNT_W(CNT_W)) bus ();

  commit_lockstep_checker #(
    .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Reference model: two record queues, one pending compare, latched diagnostics.
  rec_t        dq[$];
  rec_t        rq[$];
  int          m_state;  // 0 idle, 1 run, 2 fail
  int          m_timer;
  bit          p_vld;
  logic [2:0]  p_diff, m_field;
  logic [31:0] p_dpc, p_rpc, m_dpc, m_rpc, m_cnt;
  logic [1:0]  m_code;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    dq.delete();
    rq.delete();
    m_state = 0;
    m_timer = 0;
    p_vld   = 1'b0;
    p_diff  = '0;
    p_dpc   = '0;
    p_rpc   = '0;
    m_field = '0;
    m_dpc   = '0;
    m_rpc   = '0;
    m_cnt   = '0;
    m_code  = '0;
  endtask

  task automatic model_step();
    rec_t din, rin, d, r;
    bit pop, dovf, rovf, skew, fail;
    din = '{pc: bus.dut_pc, instr: bus.dut_instr, wdata: bus.dut_wdata};
    rin = '{pc: bus.ref_pc, instr: bus.ref_instr, wdata: bus.ref_wdata};
    if (bus.clear) begin
      model_reset();
      return;
    end
    if (m_state == 0) begin
      if (bus.en) m_state = 1;
      return;
    end
    if (m_state == 2) return;
    fail = 1'b0;
    if (p_vld) begin
      if (p_diff != 3'b000) begin
        fail = 1'b1; m_code = 2'd1; m_field = p_diff; m_dpc = p_dpc; m_rpc = p_rpc;
      end else if (m_cnt != 32'hFFFF_FFFF) begin
        m_cnt = m_cnt + 1;
      end
    end
    pop  = (dq.size() > 0) && (rq.size() > 0);
    dovf = bus.dut_valid && (dq.size() == DEPTH) && !pop;
    rovf = bus.ref_valid && (rq.size() == DEPTH) && !pop;
    skew = (dq.size() > 0) != (rq.size() > 0);
    if (!fail && (dovf || rovf || (skew && m_timer == TIMEOUT - 1))) begin
      fail    = 1'b1;
      m_code  = (dovf || rovf) ? 2'd2 : 2'd3;
      m_field = '0;
      m_dpc   = (dq.size() > 0) ? dq[0].pc : 32'h0;
      m_rpc   = (rq.size() > 0) ? rq[0].pc : 32'h0;
    end
    m_timer = skew ? m_timer + 1 : 0;
    p_vld   = pop;
    if (pop) begin
      d = dq.pop_front();
      r = rq.pop_front();
      p_diff = {d.wdata != r.wdata, d.instr != r.instr, d.pc != r.pc} & bus.cmp_mask;
      p_dpc  = d.pc;
      p_rpc  = r.pc;
    end
    if (bus.dut_valid && !dovf) dq.push_back(din);
    if (bus.ref_valid && !rovf) rq.push_back(rin);
    if (fail) m_state = 2;
  endtask

  task automatic check_all();
    check("state", bus.state, m_state);
    check("halt", bus.halt, m_state == 2);
    check("fail_code", bus.fail_code, m_code);
    check("fail_field", bus.fail_field, m_field);
    check("fail_dut_pc", bus.fail_dut_pc, m_dpc);
    check("fail_ref_pc", bus.fail_ref_pc, m_rpc);
    check("match_cnt", bus.match_cnt, m_cnt);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  function automatic rec_t mk(input int k);
    rec_t r;
    r.pc    = 32'h0001_0000 + 32'(4 * k);
    r.instr = (32'(k) * 32'h9E37_79B1) ^ 32'h0000_0013;
    r.wdata = 32'(k) * 32'h0101_0101 + 32'h55;
    return r;
  endfunction

  task automatic set_dut(input bit v, input int k);
    rec_t r = mk(k);
    bus.dut_valid = v;
    bus.dut_pc    = r.pc;
    bus.dut_instr = r.instr;
    bus.dut_wdata = r.wdata;
  endtask

  task automatic set_ref(input bit v, input int k);
    rec_t r = mk(k);
    bus.ref_valid = v;
    bus.ref_pc    = r.pc;
    bus.ref_instr = r.instr;
    bus.ref_wdata = r.wdata;
  endtask

  task automatic restart();
    bus.clear = 1'b1;
    set_dut(1'b0, 0);
    set_ref(1'b0, 0);
    cycle();
    bus.clear = 1'b0;
    bus.en    = 1'b1;
    cycle();
  endtask

  task automatic run_lockstep(input int n);
    for (int k = 1; k <= n; k++) begin
      set_dut(1'b1, k);
      set_ref(1'b1, k);
      cycle();
    end
    set_dut(1'b0, 0);
    set_ref(1'b0, 0);
    repeat (3) cycle();
  endtask

  task automatic run_mismatch(input logic [2:0] mask);
    restart();
    bus.cmp_mask = mask;
    for (int k = 1; k <= 10; k++) begin
      set_dut(1'b1, k);
      set_ref(1'b1, k);
      if (k == 7) begin
        bus.dut_wdata = 32'h1235;
        bus.ref_wdata = 32'h1234;
      end
      cycle();
      if (mask == 3'b111 && k == 8) check("halt_at_pop", bus.halt, 1'b0);
      if (mask == 3'b111 && k == 9) begin
        check("mm_halt", bus.halt, 1'b1);
        check("mm_code", bus.fail_code, 2'd1);
        check("mm_field", bus.fail_field, 3'b100);
        check("mm_dut_pc", bus.fail_dut_pc, 32'h1001C);
        check("mm_ref_pc", bus.fail_ref_pc, 32'h1001C);
        check("mm_cnt", bus.match_cnt, 6);
      end
    end
    set_dut(1'b0, 0);
    set_ref(1'b0, 0);
    repeat (3) cycle();
    bus.cmp_mask = 3'b111;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1000000");
    $fatal(1);
  end

  initial begin
    int dk, rk;
    bus.en = 1'b0;
    bus.clear = 1'b0;
    bus.cmp_mask = 3'b111;
    set_dut(1'b0, 0);
    set_ref(1'b0, 0);
    model_reset();
    #1 rst_n = 1'b0;
    #11;
    check_all();
    check("rst_state", bus.state, 2'd0);
    #1 rst_n = 1'b1;

    // Lockstep match.
    bus.en = 1'b1;
    cycle();
    run_lockstep(100);
    check("lock_cnt", bus.match_cnt, 100);
    check("lock_state", bus.state, 2'd1);
    check("lock_halt", bus.halt, 1'b0);

    // REF lags DUT by 5 cycles.
    restart();
    for (int t = 0; t < 55; t++) begin
      set_dut(t < 50, t + 1);
      set_ref(t >= 5, t - 4);
      cycle();
    end
    set_dut(1'b0, 0);
    set_ref(1'b0, 0);
    repeat (3) cycle();
    check("skew_cnt", bus.match_cnt, 50);
    check("skew_code", bus.fail_code, 2'd0);

    run_mismatch(3'b111);
    check("mm_sticky", bus.state, 2'd2);
    run_mismatch(3'b011);
    check("mask_cnt", bus.match_cnt, 10);
    check("mask_code", bus.fail_code, 2'd0);

    // Overflow: nine DUT pushes, REF idle.
    restart();
    for (int k = 1; k <= 9; k++) begin
      set_dut(1'b1, k);
      cycle();
      if (k == 8) check("ovf_pre_state", bus.state, 2'd1);
    end
    set_dut(1'b0, 0);
    check("ovf_code", bus.fail_code, 2'd2);
    check("ovf_ref_pc", bus.fail_ref_pc, 32'h0);
    check("ovf_dut_pc", bus.fail_dut_pc, 32'h10004);

    // Recovery by clear.
    bus.clear = 1'b1;
    cycle();
    bus.clear = 1'b0;
    check("clr_state", bus.state, 2'd0);
    check("clr_halt", bus.halt, 1'b0);
    check("clr_code", bus.fail_code, 2'd0);
    check("clr_cnt", bus.match_cnt, 0);
    cycle();
    run_lockstep(100);
    check("rerun_cnt", bus.match_cnt, 100);

    // Timeout with REF silent.
    restart();
    set_dut(1'b1, 1);
    cycle();
    set_dut(1'b0, 0);
    for (int i = 1; i <= 16; i++) begin
      cycle();
      if (i == 15) check("to_pre_state", bus.state, 2'd1);
    end
    check("to_code", bus.fail_code, 2'd3);
    check("to_dut_pc", bus.fail_dut_pc, 32'h10004);

    // REF answers at cycle 15: just in time.
    restart();
    set_dut(1'b1, 1);
    cycle();
    set_dut(1'b0, 0);
    repeat (14) cycle();
    set_ref(1'b1, 1);
    cycle();
    set_ref(1'b0, 0);
    repeat (3) cycle();
    check("to_ok_cnt", bus.match_cnt, 1);
    check("to_ok_code", bus.fail_code, 2'd0);

    // Asynchronous reset mid-RUN.
    restart();
    for (int k = 1; k <= 5; k++) begin
      set_dut(1'b1, k);
      set_ref(1'b1, k);
      cycle();
    end
    set_dut(1'b0, 0);
    set_ref(1'b0, 0);
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    check("arst_cnt", bus.match_cnt, 0);
    #2 rst_n = 1'b1;

    // Randomized traffic.
    restart();
    dk = 0;
    rk = 0;
    for (int c = 0; c < 3000; c++) begin
      bit clr, dv, rv;
      clr = (m_state == 2 && $urandom_range(0, 7) == 0) || $urandom_range(0, 499) == 0;
      bus.clear = clr;
      bus.en = $urandom_range(0, 9) != 0;
      bus.cmp_mask = ($urandom_range(0, 3) != 0) ? 3'b111 : 3'($urandom_range(0, 7));
      dv = $urandom_range(0, 99) < 55;
      rv = $urandom_range(0, 99) < 55;
      set_dut(dv, dk + 1);
      set_ref(rv, rk + 1);
      if (dv && $urandom_range(0, 59) == 0) begin
        bus.dut_wdata = bus.dut_wdata ^ (32'h1 << $urandom_range(0, 31));
      end
      if (clr) begin
        dk = 0;
        rk = 0;
      end else if (m_state == 1) begin
        dk += int'(dv);
        rk += int'(rv);
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/commit_lockstep_checker.md
# commit_lockstep_checker

Compares retired-instruction streams from the design core and the reference core, running side by side in simulation, one commit record at a time. Each side pushes records into its own skew FIFO, so the two cores may retire at different rates; matched heads are popped together and compared under a runtime field mask. On mismatch, overflow or excessive skew the block latches diagnostic state and asserts a halt request that drives the `kill` input of both cores. It sits in the testbench hierarchy next to the core/TCM pairs.

## Interface
- XLEN, 32, width of pc and writeback data
- ILEN, 32, instruction width
- DEPTH, 8, entries per skew FIFO; power of two, >= 2
- TIMEOUT, 256, cycles one FIFO may hold entries while the other is empty before failing
- CNT_W, 32, width of match counter

- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- en  in  1  level; start checking from IDLE
- clear  in  1  pulse; flush FIFOs, return to IDLE
- cmp_mask  in  3  bit0 pc, bit1 instr, bit2 wdata; sampled at pop
- dut_valid  in  1  design core retired a record this cycle
- dut_pc / dut_instr / dut_wdata  in  XLEN/ILEN/XLEN  design core commit record
- ref_valid  in  1  reference core retired a record this cycle
- ref_pc / ref_instr / ref_wdata  in  XLEN/ILEN/XLEN  reference core commit record
- state  out  2  0 IDLE, 1 RUN, 2 FAIL
- halt  out  1  kill request to both cores; high in FAIL
- fail_code  out  2  0 none, 1 MISMATCH, 2 OVERFLOW, 3 TIMEOUT
- fail_dut_pc / fail_ref_pc  out  XLEN  pc at head of each FIFO at failure
- fail_field  out  3  mask-qualified per-field mismatch bits
- match_cnt  out  CNT_W  matched records, saturating

## Operation
- IDLE: valid inputs ignored, FIFOs empty. en=1 -> RUN next cycle.
- RUN: dut_valid pushes {pc,instr,wdata} into the DUT FIFO; ref_valid pushes into the REF FIFO.
- Pop: when both FIFOs are non-empty, pop both heads in the same cycle, compare (dut ^ ref) per field, AND with cmp_mask, and register the result.
- Registered result:
  - nonzero -> FAIL, fail_code=1, fail_field=result, fail_*_pc=popped pcs;
  - zero -> match_cnt+1, saturating at all-ones.
- Overflow: a push to a FIFO that is full and not popping that cycle -> FAIL, fail_code=2. fail_*_pc hold the current heads, or 0 for an empty side. The offending record is dropped.
- Skew timer: counts cycles with exactly one FIFO non-empty; resets when both are empty or a pop occurs. Reaching TIMEOUT -> FAIL, fail_code=3.
- Failure priority within a cycle: MISMATCH > OVERFLOW > TIMEOUT.
- FAIL: sticky, pushes ignored, diagnostics frozen, halt=1.
- clear (any state): flushes FIFOs and the skew timer, zeroes the diagnostics, goes to IDLE next cycle; match_cnt is zeroed too. clear beats en and any failure in the same cycle.
- Disabled field: cmp_mask=0 makes every popped pair a match.
- en low in RUN has no effect; only clear exits RUN.

## Timing
- Reset: state=IDLE, halt=0, fail_code=0, fail_field=0, fail_*_pc=0, match_cnt=0, FIFOs empty, timer 0.
- Reset asserted mid-operation clears everything immediately (asynchronous), regardless of state.
- Push-to-pop: a record pushed in cycle N can be popped no earlier than cycle N+1.
- Compare latency: pop in cycle N -> match_cnt or FAIL/halt visible after the edge ending cycle N+1.
- Halt is registered: two edges after the mismatching pop. Records retiring meanwhile are pushed, or ignored once in FAIL.
- Full FIFO with a pop in the same cycle accepts a push (no overflow).
- Both sides valid with both FIFOs empty: push both; pop next cycle.
- Pointers wrap modulo DEPTH; full/empty are distinguished by an extra pointer bit.
- TIMEOUT: fail flag set on the edge where the timer equals TIMEOUT-1 and the skew condition still holds.

## Test plan
- Lockstep match: en=1; 100 identical records on both sides, same cycle, cmp_mask=7 -> match_cnt=100, state=RUN, halt=0.
- Skewed match: REF retires each record 5 cycles after DUT, DEPTH=8, 50 records -> match_cnt=50, no failure.
- Mismatch: record 7 has ref_wdata=0x1234 and dut_wdata=0x1235 at pc 0x1001C.
  - cmp_mask=7 -> fail_code=1, fail_field=3'b100, fail_*_pc=0x1001C, halt two edges after the pop, match_cnt=6.
  - Repeat with cmp_mask=3 -> no failure.
- Overflow: DEPTH=8; DUT pushes 9 records, REF idle -> fail_code=2 on the 9th push, fail_ref_pc=0.
- Timeout: TIMEOUT=16; DUT pushes 1 record, REF silent -> FAIL with fail_code=3 after 16 cycles; one REF push at cycle 15 instead -> match, no failure.
- Recovery: in FAIL, pulse clear -> IDLE with all outputs zero; re-run the lockstep test -> pass. Assert rst_n low mid-RUN -> reset values immediately.
